// File: rtl/riscv_ifu_fetch_queue_pkg.sv
// Shared IFU types: the 16-bit instruction parcel, the RVC length test and
// the default reset fetch address.
package riscv_pkg;

  typedef logic [15:0] parcel_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0200;

  // A parcel starts a compressed instruction unless its two low bits are 11.
  function automatic logic is_compressed(parcel_t p);
    return p[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_ifu_fetch_queue_if.sv
// Fetch-side request/response bus plus the decode-side instruction handshake.
// The master modport is the fetch queue; the slave modport is its environment.
interface riscv_ifu_fetch_queue_if #(
  parameter int FETCH_W = 32
);

  logic               req_vld;
  logic [31:0]        req_addr;
  logic               req_ack;
  logic               rsp_vld;
  logic [31:0]        rsp_addr;
  logic [FETCH_W-1:0] rsp_data;
  logic               rsp_ack;
  logic               ifu_vld;
  logic               ifu_rdy;
  logic [31:0]        ifu_addr;
  logic [31:0]        ifu_data;
  logic               ifu_cmp;

  modport master (
    output req_vld, req_addr, rsp_ack, ifu_vld, ifu_addr, ifu_data, ifu_cmp,
    input  req_ack, rsp_vld, rsp_addr, rsp_data, ifu_rdy
  );

  modport slave (
    input  req_vld, req_addr, rsp_ack, ifu_vld, ifu_addr, ifu_data, ifu_cmp,
    output req_ack, rsp_vld, rsp_addr, rsp_data, ifu_rdy
  );

endinterface

// File: rtl/riscv_ifu_fetch_queue_fifo.sv
// Circular parcel buffer: pushes 0..HW parcels at the tail, pops 0..2 at the
// head, and exposes the two head parcels for instruction alignment.
module riscv_parcel_fifo
  import riscv_pkg::*;
#(
  parameter  int HW       = 2,
  parameter  int DEPTH_HW = 8,
  localparam int PTR_W    = $clog2(DEPTH_HW),
  localparam int CNT_W    = PTR_W + 1,
  localparam int PUSH_W   = $clog2(HW + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [PUSH_W-1:0] push_n,
  input  parcel_t           push_data [HW],
  input  logic [1:0]        pop_n,
  output parcel_t           peek0,
  output parcel_t           peek1,
  output logic [CNT_W-1:0]  count
);

  typedef logic [PTR_W-1:0] ptr_t;

  parcel_t mem [DEPTH_HW];
  ptr_t    head;
  ptr_t    tail;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(pop_n);
      tail  <= tail + ptr_t'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // NOTE: the storage array is deliberately not reset; head, tail and count
  // alone decide which entries hold live parcels.
  always_ff @(posedge clock) begin
    for (int i = 0; i < HW; i++) begin
      if (i < int'(push_n)) mem[tail + ptr_t'(i)] <= push_data[i];
    end
  end

  assign peek0 = mem[head];
  assign peek1 = mem[head + ptr_t'(1)];

endmodule

// File: rtl/riscv_ifu_fetch_queue.sv
// Sequential instruction fetch queue: credit-limited requests, in-order
// response capture with stale-address drop, and RVC/32-bit output alignment.
module riscv_ifu_fetch_queue
  import riscv_pkg::*;
#(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect_vld,
  input  logic [31:0]             redirect_pc,
  riscv_ifu_fetch_queue_if.master bus
);

  localparam int          HW         = FETCH_W / 16;
  localparam int          OFF_W      = $clog2(FETCH_W / 8);
  localparam int          SKIP_W     = OFF_W - 1;
  localparam int          CNT_W      = $clog2(DEPTH_HW) + 1;
  localparam int          PUSH_W     = $clog2(HW + 1);
  localparam int          OUT_W      = 3;
  localparam logic [31:0] STEP       = 32'(FETCH_W / 8);
  localparam logic [31:0] ALIGN_MASK = ~(STEP - 32'd1);

  logic [31:0]        fetch_pc;
  logic [31:0]        exp_addr;
  logic [31:0]        head_pc;
  logic [SKIP_W-1:0]  skip;
  logic [OUT_W-1:0]   out_cnt;

  logic [CNT_W-1:0]   count;
  parcel_t            p0;
  parcel_t            p1;
  parcel_t            push_data [HW];
  logic [PUSH_W-1:0]  push_n;
  logic [1:0]         pop_n;
  logic [FETCH_W-1:0] rsp_shift;
  logic               req_ok;
  logic               req_fire;
  logic               rsp_hit;
  logic               p0_cmp;
  logic               out_vld;
  logic               pop;

  // Leading parcels before the redirect target are shifted out before the push.
  assign rsp_shift = bus.rsp_data >> {skip, 4'b0000};

  for (genvar g = 0; g < HW; g++) begin : g_split
    assign push_data[g] = rsp_shift[16*g +: 16];
  end

  // NOTE: combinational logic gives every output a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    req_ok   = !redirect_vld && (int'(out_cnt) < MAX_OUT) &&
               ((DEPTH_HW - int'(count)) >= (int'(out_cnt) + 1) * HW);
    req_fire = req_ok && bus.req_ack;
    rsp_hit  = bus.rsp_vld && (bus.rsp_addr == exp_addr) && !redirect_vld;
    push_n   = rsp_hit ? PUSH_W'(HW - int'(skip)) : '0;

    p0_cmp   = is_compressed(p0);
    out_vld  = ((count != '0) && p0_cmp) || (count >= CNT_W'(2));
    pop      = out_vld && bus.ifu_rdy && !redirect_vld;
    pop_n    = pop ? (p0_cmp ? 2'd1 : 2'd2) : 2'd0;
  end

  always_comb begin
    bus.req_vld  = req_ok;
    bus.req_addr = fetch_pc;
    bus.rsp_ack  = bus.rsp_vld;
    bus.ifu_vld  = out_vld;
    bus.ifu_addr = head_pc;
    bus.ifu_cmp  = p0_cmp;
    bus.ifu_data = p0_cmp ? {16'h0000, p0} : {p1, p0};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC & ALIGN_MASK;
      exp_addr <= RESET_PC & ALIGN_MASK;
      head_pc  <= RESET_PC & ~32'd1;
      skip     <= RESET_PC[OFF_W-1:1];
      out_cnt  <= '0;
    end else begin
      // Credits track every acked response, including the stale ones dropped.
      out_cnt <= out_cnt + OUT_W'(req_fire) - OUT_W'(bus.rsp_vld);
      if (redirect_vld) begin
        fetch_pc <= redirect_pc & ALIGN_MASK;
        exp_addr <= redirect_pc & ALIGN_MASK;
        head_pc  <= redirect_pc & ~32'd1;
        skip     <= redirect_pc[OFF_W-1:1];
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (rsp_hit) begin
          exp_addr <= exp_addr + STEP;
          skip     <= '0;
        end
        if (pop) head_pc <= head_pc + (p0_cmp ? 32'd2 : 32'd4);
      end
    end
  end

  riscv_parcel_fifo #(
    .HW       (HW),
    .DEPTH_HW (DEPTH_HW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (redirect_vld),
    .push_n    (push_n),
    .push_data (push_data),
    .pop_n     (pop_n),
    .peek0     (p0),
    .peek1     (p1),
    .count     (count)
  );

endmodule

// File: tb/tb_riscv_ifu_fetch_queue.sv
// Directed bench for riscv_ifu_fetch_queue: a per-cycle vector table for the
// fetch/align/redirect cases, then streamed sequences for backpressure and wrap.
module tb_riscv_ifu_fetch_queue;

  localparam int FETCH_W  = 32;
  localparam int HW       = 2;
  localparam int DEPTH_HW = 8;
  localparam int MAX_OUT  = 2;

  logic        clock;
  logic        reset;
  logic        redirect_vld;
  logic [31:0] redirect_pc;

  riscv_ifu_fetch_queue_if #(.FETCH_W(FETCH_W)) bus ();

  riscv_ifu_fetch_queue #(
    .FETCH_W  (FETCH_W),
    .DEPTH_HW (DEPTH_HW),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (32'h0000_0200)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .bus          (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        rack;
    logic        rv;
    logic [31:0] ra;
    logic [31:0] rd;
    logic        rdy;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_ia;
    logic [31:0] e_id;
    logic        e_ic;
  } vec_t;

  vec_t        vq [$];
  logic [31:0] pending [$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          m_out, m_count;
  logic [31:0] m_fetch, m_pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic redir, input logic [31:0] rpc, input logic rack,
                     input logic rv, input logic [31:0] ra, input logic [31:0] rd,
                     input logic rdy, input logic e_rv, input logic [31:0] e_ra,
                     input logic e_iv, input logic [31:0] e_ia, input logic [31:0] e_id,
                     input logic e_ic);
    vec_t v;
    v = '{redir, rpc, rack, rv, ra, rd, rdy, e_rv, e_ra, e_iv, e_ia, e_id, e_ic};
    vq.push_back(v);
  endtask

  // Synthetic program memory: every parcel is a distinct compressed instruction.
  function automatic logic [15:0] parcel(input logic [31:0] p);
    return {p[14:1], 2'b01};
  endfunction

  // Acts as the fetch-side driver (one-cycle response latency) and checks all
  // outputs against a counting model of queue occupancy and credits.
  task automatic stream(input int n, input bit ack_en, input bit rdy);
    for (int c = 0; c < n; c++) begin
      logic        exp_rv, exp_iv, sent, acc, pop;
      logic [31:0] a;
      @(negedge clock);
      redirect_vld  = 1'b0;
      bus.req_ack   = ack_en;
      bus.ifu_rdy   = rdy;
      sent          = pending.size() > 0;
      a             = sent ? pending[0] : 32'h0;
      bus.rsp_vld   = sent;
      bus.rsp_addr  = a;
      bus.rsp_data  = {parcel(a + 32'd2), parcel(a)};
      #1;
      exp_rv = (m_out < MAX_OUT) && ((DEPTH_HW - m_count) >= (m_out + 1) * HW);
      exp_iv = m_count >= 1;
      check("stream req_vld", bus.req_vld, exp_rv);
      check("stream rsp_ack", bus.rsp_ack, sent);
      check("stream ifu_vld", bus.ifu_vld, exp_iv);
      if (exp_iv && bus.ifu_vld) begin
        check("stream ifu_addr", bus.ifu_addr, m_pc);
        check("stream ifu_data", bus.ifu_data, {16'h0, parcel(m_pc)});
        check("stream ifu_cmp", bus.ifu_cmp, 1'b1);
      end
      acc = exp_rv && ack_en;
      if (acc) begin
        check("stream req_addr", bus.req_addr, m_fetch);
        pending.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
      end
      pop = exp_iv && rdy;
      if (pop) m_pc = m_pc + 32'd2;
      if (sent) void'(pending.pop_front());
      m_count = m_count + (sent ? 2 : 0) - (pop ? 1 : 0);
      m_out   = m_out + (acc ? 1 : 0) - (sent ? 1 : 0);
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    @(negedge clock);
    redirect_vld = 1'b1;
    redirect_pc  = pc;
    bus.req_ack  = 1'b1;
    bus.rsp_vld  = 1'b0;
    bus.ifu_rdy  = 1'b1;
    #1;
    check("redirect req_vld", bus.req_vld, 1'b0);
    m_fetch = pc & ~32'd3;
    m_pc    = pc & ~32'd1;
    m_count = 0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = '0;
    bus.req_ack  = 1'b0;
    bus.rsp_vld  = 1'b0;
    bus.rsp_addr = '0;
    bus.rsp_data = '0;
    bus.ifu_rdy  = 1'b0;

    //  redir rpc    rack rv ra     rd            rdy  e_rv e_ra   e_iv e_ia   e_id          e_ic
    // Reset and two sequential 32-bit instructions.
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        0,   1, 32'h200,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h200,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h204,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h200, 32'h00130013, 0,   0, 32'h208,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h204, 32'h00000513, 1,   1, 32'h208,  1, 32'h200, 32'h00130013, 0);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        1,   1, 32'h208,  1, 32'h204, 32'h00000513, 0);
    // Restart at 0x200 with an RVC instruction and a straddling 32-bit one.
    add(1, 32'h200,  0, 0, 32'h0,   32'h0,        0,   0, 32'h208,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h200,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h200, 32'h05134501, 0,   1, 32'h204,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        1,   1, 32'h204,  1, 32'h200, 32'h00004501, 1);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        1,   1, 32'h204,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        1,   1, 32'h208,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h204, 32'h00010000, 1,   1, 32'h208,  0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        1,   1, 32'h208,  1, 32'h202, 32'h00000513, 0);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        0,   1, 32'h208,  1, 32'h206, 32'h00000001, 1);
    // Two requests in flight, then redirect to 0x1006; stale responses dropped.
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h208,  1, 32'h206, 32'h00000001, 1);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h20C,  1, 32'h206, 32'h00000001, 1);
    add(1, 32'h1006, 0, 0, 32'h0,   32'h0,        1,   0, 32'h210,  1, 32'h206, 32'h00000001, 1);
    add(0, 32'h0,    0, 1, 32'h208, 32'hDEADBEEF, 1,   0, 32'h1004, 0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h20C, 32'h12345678, 0,   1, 32'h1004, 0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h1004, 0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h1004,32'h4411FFFF, 1,   1, 32'h1008, 0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        1,   1, 32'h1008, 1, 32'h1006,32'h00004411, 1);
    // Redirect colliding with a matching response and a decode pop.
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h1008, 0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    0, 1, 32'h1008,32'h00050001, 0,   1, 32'h100C, 0, 32'h0,   32'h0,        0);
    add(0, 32'h0,    1, 0, 32'h0,   32'h0,        0,   1, 32'h100C, 1, 32'h1008,32'h00000001, 1);
    add(1, 32'h2000, 0, 1, 32'h100C,32'h00090009, 1,   0, 32'h1010, 1, 32'h1008,32'h00000001, 1);
    add(0, 32'h0,    0, 0, 32'h0,   32'h0,        0,   1, 32'h2000, 0, 32'h0,   32'h0,        0);

    repeat (3) @(posedge clock);

    foreach (vq[i]) begin
      @(negedge clock);
      reset        = 1'b0;
      redirect_vld = vq[i].redir;
      redirect_pc  = vq[i].rpc;
      bus.req_ack  = vq[i].rack;
      bus.rsp_vld  = vq[i].rv;
      bus.rsp_addr = vq[i].ra;
      bus.rsp_data = vq[i].rd;
      bus.ifu_rdy  = vq[i].rdy;
      #1;
      check($sformatf("v%0d req_vld", i), bus.req_vld, vq[i].e_rv);
      check($sformatf("v%0d req_addr", i), bus.req_addr, vq[i].e_ra);
      check($sformatf("v%0d rsp_ack", i), bus.rsp_ack, vq[i].rv);
      check($sformatf("v%0d ifu_vld", i), bus.ifu_vld, vq[i].e_iv);
      if (vq[i].e_iv) begin
        check($sformatf("v%0d ifu_addr", i), bus.ifu_addr, vq[i].e_ia);
        check($sformatf("v%0d ifu_data", i), bus.ifu_data, vq[i].e_id);
        check($sformatf("v%0d ifu_cmp", i), bus.ifu_cmp, vq[i].e_ic);
      end
    end

    // Backpressure: queue fills, requests throttle, then in-order drain.
    m_fetch = 32'h2000;
    m_pc    = 32'h2000;
    m_count = 0;
    m_out   = 0;
    stream(20, 1'b1, 1'b0);
    stream(24, 1'b1, 1'b1);
    stream(6, 1'b0, 1'b1);

    // Address wrap through 0xFFFFFFFC and repeated queue pointer wrap.
    do_redirect(32'hFFFF_FFFC);
    stream(16, 1'b1, 1'b1);
    stream(4, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
